// File: rtl/mp3_decoder_top_if.sv
// mp3_decoder_top_if: bitstream byte handshake plus the side-info RAM write port.
// The decoder connects through the slave modport; the byte source and RAM side use master.
interface mp3_decoder_top_if;
    logic [7:0]  bs_data;
    logic        bs_valid;
    logic        bs_ready;
    logic        ram0_we;
    logic [1:0]  ram0_address;
    logic [15:0] ram0_datain;

    modport master (output bs_data, bs_valid,
                    input  bs_ready, ram0_we, ram0_address, ram0_datain);
    modport slave  (input  bs_data, bs_valid,
                    output bs_ready, ram0_we, ram0_address, ram0_datain);
endinterface

// File: rtl/mp3_decoder_top.sv
// mp3_decoder_top: MP3 layer III frame sync, header check and side-info extraction to ram0.
// Optional DEBUG_HUFF_EN exposes the state register and a frame counter on the dbg_* ports.
//
//  state        | meaning
//  IDLE         | wait for a frame credit (1152 sample ticks) and module_en
//  SYNC1        | hunt for 0xFF
//  SYNC2        | check sync tail, ID and layer; latch protection bit
//  HDR3         | reject bad bitrate / samplerate index
//  HDR4         | latch channel mode
//  CRC          | drop the two CRC bytes
//  FRAME_START  | one cycle: consume credit, count frame, HUFF_done low
//  SI_HDR       | skip main_data_begin, private bits, scfsi
//  SI_FIELDS    | read part2_3_length .. window_switching_flag
//  SI_TAIL      | read block_type/mixed or skipped bits, plus 3 trailing bits
//  SI_NEXT      | advance granule/channel or finish the frame
//  WRITE        | one-cycle ram0 write of the packed side-info word
module mp3_decoder_top (
    input  logic              MASTER_CLOCK_I,
    input  logic              global_rst_n,
    input  logic              module_en,
    input  logic              sample_clk,
    mp3_decoder_top_if.slave  bus,
    output logic              ETH_done,
    output logic              HUFF_done,
    output logic [3:0]        dbg_state,
    output logic [15:0]       dbg_frame_count
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        SYNC1       = 4'd1,
        SYNC2       = 4'd2,
        HDR3        = 4'd3,
        HDR4        = 4'd4,
        CRC         = 4'd5,
        FRAME_START = 4'd6,
        SI_HDR      = 4'd7,
        SI_FIELDS   = 4'd8,
        SI_TAIL     = 4'd9,
        SI_NEXT     = 4'd10,
        WRITE       = 4'd11
    } state_t;

    state_t      state;
    logic [2:0]  sc_sync;
    logic        sc_rise;
    logic [10:0] sample_cnt;
    logic        sample_wrap;
    logic        credit;
    logic        mono;
    logic        prot;
    logic        crc_left;
    logic        gr;
    logic        ch;
    logic        last_gc;
    logic [7:0]  cur_byte;
    logic [3:0]  bit_left;
    logic [5:0]  field_cnt;
    logic [11:0] acc;
    logic [12:0] acc_nxt;
    logic [7:0]  gg;
    logic [3:0]  sfc;
    logic        wsf;
    logic [1:0]  bt;
    logic        mx;
    logic        byte_state;

    assign sc_rise     = sc_sync[1] & ~sc_sync[2];
    assign sample_wrap = sc_rise && (sample_cnt == 11'd1151);
    assign acc_nxt     = {acc, cur_byte[7]};
    assign last_gc     = gr && (mono || ch);

    // Sample counting runs regardless of module_en; a wrap in the FRAME_START cycle wins.
    always_ff @(posedge MASTER_CLOCK_I or posedge global_rst_n) begin
        if (global_rst_n) begin
            sc_sync    <= 3'b000;
            sample_cnt <= 11'd0;
            credit     <= 1'b1;
        end else begin
            sc_sync <= {sc_sync[1:0], sample_clk};
            if (sc_rise)
                sample_cnt <= sample_wrap ? 11'd0 : sample_cnt + 11'd1;
            if (sample_wrap)
                credit <= 1'b1;
            else if (module_en && state == FRAME_START)
                credit <= 1'b0;
        end
    end

    always_comb begin
        byte_state = 1'b0;
        case (state)
            SYNC1, SYNC2, HDR3, HDR4, CRC:  byte_state = 1'b1;
            SI_HDR, SI_FIELDS, SI_TAIL:     byte_state = (bit_left == 4'd0);
            default:                        byte_state = 1'b0;
        endcase
    end

    assign bus.bs_ready = module_en && byte_state;

    always_ff @(posedge MASTER_CLOCK_I or posedge global_rst_n) begin
        if (global_rst_n) begin
            state            <= IDLE;
            mono             <= 1'b0;
            prot             <= 1'b1;
            crc_left         <= 1'b0;
            gr               <= 1'b0;
            ch               <= 1'b0;
            cur_byte         <= 8'd0;
            bit_left         <= 4'd0;
            field_cnt        <= 6'd0;
            acc              <= 12'd0;
            gg               <= 8'd0;
            sfc              <= 4'd0;
            wsf              <= 1'b0;
            bt               <= 2'd0;
            mx               <= 1'b0;
            bus.ram0_we      <= 1'b0;
            bus.ram0_address <= 2'd0;
            bus.ram0_datain  <= 16'd0;
            ETH_done         <= 1'b1;
            HUFF_done        <= 1'b1;
        end else begin
            bus.ram0_we <= 1'b0;
            if (module_en) begin
                case (state)
                    IDLE: if (credit) begin
                        state    <= SYNC1;
                        ETH_done <= 1'b0;
                    end
                    SYNC1: if (bus.bs_valid && bus.bs_data == 8'hFF)
                        state <= SYNC2;
                    SYNC2: if (bus.bs_valid) begin
                        if (bus.bs_data[7:5] == 3'b111 && bus.bs_data[3] && bus.bs_data[2:1] == 2'b01) begin
                            prot  <= bus.bs_data[0];
                            state <= HDR3;
                        end else if (bus.bs_data != 8'hFF) begin
                            state <= SYNC1;
                        end
                    end
                    HDR3: if (bus.bs_valid) begin
                        if (bus.bs_data[7:4] == 4'd0 || bus.bs_data[7:4] == 4'd15 || bus.bs_data[3:2] == 2'd3)
                            state <= SYNC1;
                        else
                            state <= HDR4;
                    end
                    HDR4: if (bus.bs_valid) begin
                        mono     <= (bus.bs_data[7:6] == 2'b11);
                        crc_left <= 1'b1;
                        if (prot) begin
                            state     <= FRAME_START;
                            HUFF_done <= 1'b0;
                        end else begin
                            state <= CRC;
                        end
                    end
                    CRC: if (bus.bs_valid) begin
                        if (crc_left) begin
                            crc_left <= 1'b0;
                        end else begin
                            state     <= FRAME_START;
                            HUFF_done <= 1'b0;
                        end
                    end
                    FRAME_START: begin
                        state     <= SI_HDR;
                        field_cnt <= mono ? 6'd18 : 6'd20;
                        bit_left  <= 4'd0;
                        gr        <= 1'b0;
                        ch        <= 1'b0;
                    end
                    SI_HDR, SI_FIELDS, SI_TAIL: begin
                        if (bit_left == 4'd0) begin
                            if (bus.bs_valid) begin
                                cur_byte <= bus.bs_data;
                                bit_left <= 4'd8;
                            end
                        end else begin
                            cur_byte  <= {cur_byte[6:0], 1'b0};
                            bit_left  <= bit_left - 4'd1;
                            acc       <= acc_nxt[11:0];
                            field_cnt <= field_cnt - 6'd1;
                            // third tail bit completes block_type + mixed_block_flag
                            if (state == SI_TAIL && field_cnt == 6'd23) begin
                                bt <= acc_nxt[2:1];
                                mx <= acc_nxt[0];
                            end
                            if (field_cnt == 6'd1) begin
                                if (state == SI_HDR) begin
                                    state     <= SI_FIELDS;
                                    field_cnt <= 6'd34;
                                end else if (state == SI_FIELDS) begin
                                    state     <= SI_TAIL;
                                    field_cnt <= 6'd25;
                                    gg        <= acc_nxt[12:5];
                                    sfc       <= acc_nxt[4:1];
                                    wsf       <= acc_nxt[0];
                                end else begin
                                    state            <= WRITE;
                                    bus.ram0_we      <= 1'b1;
                                    bus.ram0_address <= {gr, ch};
                                    bus.ram0_datain  <= {gg, sfc, wsf, wsf ? bt : 2'b00, wsf ? mx : 1'b0};
                                    if (last_gc)
                                        ETH_done <= 1'b1;
                                end
                            end
                        end
                    end
                    WRITE: state <= SI_NEXT;
                    SI_NEXT: begin
                        if (last_gc) begin
                            state     <= IDLE;
                            HUFF_done <= 1'b1;
                        end else begin
                            if (!mono && !ch) begin
                                ch <= 1'b1;
                            end else begin
                                gr <= 1'b1;
                                ch <= 1'b0;
                            end
                            state     <= SI_FIELDS;
                            field_cnt <= 6'd34;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DEBUG_HUFF_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge MASTER_CLOCK_I or posedge global_rst_n) begin
        if (global_rst_n)
            frame_cnt <= 16'd0;
        else if (module_en && state == FRAME_START)
            frame_cnt <= frame_cnt + 16'd1;
    end

    assign dbg_state       = state;
    assign dbg_frame_count = frame_cnt;
`else
    assign dbg_state       = 4'd0;
    assign dbg_frame_count = 16'd0;
`endif
endmodule

// File: tb/tb_mp3_decoder_top.sv
// tb_mp3_decoder_top: directed frames with a write scoreboard built from the bitstream generator.
`timescale 1ns/1ps
module tb_mp3_decoder_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic module_en = 1'b0;
    logic sample_clk = 1'b0;
    logic eth_done, huff_done;
    logic [3:0]  dbg_state;
    logic [15:0] dbg_frame_count;

    mp3_decoder_top_if bus();

    mp3_decoder_top dut (
        .MASTER_CLOCK_I  (clk),
        .global_rst_n    (rst),
        .module_en       (module_en),
        .sample_clk      (sample_clk),
        .bus             (bus),
        .ETH_done        (eth_done),
        .HUFF_done       (huff_done),
        .dbg_state       (dbg_state),
        .dbg_frame_count (dbg_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gg;
        logic [3:0] sfc;
        logic       wsf;
        logic [1:0] bt;
        logic       mx;
    } gc_t;

    int checks = 0;
    int errors = 0;
    logic [17:0] sb[$];
    logic [7:0]  txq[$];
    bit          bitq[$];
    gc_t         gcs[4];
    int acc_cnt = 0, wr_cnt = 0, st6_cnt = 0, huff_fall = 0;
    int base, w0, f0, a1, len, t;
    logic huff_q = 1'b1;
    bit   abort = 1'b0;
    bit   en_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.bs_valid && bus.bs_ready) acc_cnt++;
        if (dbg_state == 4'd6) st6_cnt++;
        if (huff_q && !huff_done) huff_fall++;
        huff_q = huff_done;
        if (bus.ram0_we) begin
            wr_cnt++;
            chk("write_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0)
                chk("write_addr_data", {14'd0, bus.ram0_address, bus.ram0_datain}, {14'd0, sb.pop_front()});
        end
    end

    task automatic put_bits(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    task automatic flush_bits();
        while (bitq.size() != 0) begin
            logic [7:0] b;
            b = 8'h00;
            for (int i = 7; i >= 0; i--) if (bitq.size() != 0) b[i] = bitq.pop_front();
            txq.push_back(b);
        end
    endtask

    // Side info with random filler in every skipped/unused field; expected ram0 words queued.
    task automatic add_side_info(input bit mono, input bit expect_wr);
        int  nch;
        gc_t g;
        nch = mono ? 1 : 2;
        put_bits(9, $urandom);
        put_bits(mono ? 5 : 3, $urandom);
        put_bits(4 * nch, $urandom);
        for (int gr = 0; gr < 2; gr++) begin
            for (int ch = 0; ch < nch; ch++) begin
                g = gcs[gr * 2 + ch];
                put_bits(12, $urandom);
                put_bits(9, $urandom);
                put_bits(8, {24'd0, g.gg});
                put_bits(4, {28'd0, g.sfc});
                put_bits(1, {31'd0, g.wsf});
                if (g.wsf) begin
                    put_bits(2, {30'd0, g.bt});
                    put_bits(1, {31'd0, g.mx});
                    put_bits(19, $urandom);
                end else begin
                    put_bits(22, $urandom);
                end
                put_bits(3, $urandom);
                if (expect_wr)
                    sb.push_back({2'(gr * 2 + ch), g.gg, g.sfc, g.wsf,
                                  g.wsf ? g.bt : 2'b00, g.wsf ? g.mx : 1'b0});
            end
        end
        flush_bits();
    endtask

    task automatic send_all();
        int tw;
        while (txq.size() != 0 && !abort) begin
            tw = 0;
            @(posedge clk); #1;
            bus.bs_data  = txq.pop_front();
            bus.bs_valid = 1'b1;
            @(negedge clk);
            while (!bus.bs_ready && !abort && tw < 20000) begin
                @(negedge clk);
                tw++;
            end
            if (tw >= 20000) begin
                chk("accept_timeout", {31'd0, bus.bs_ready}, 32'd1);
                txq.delete();
            end
        end
        @(posedge clk); #1;
        bus.bs_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int tw;
        tw = 0;
        @(negedge clk);
        while (!(huff_done && sb.size() == 0) && tw < 5000) begin
            @(negedge clk);
            tw++;
        end
        chk({tag, "_done_in_time"}, {31'd0, tw < 5000}, 32'd1);
    endtask

    task automatic pulse_samples(input int n);
        repeat (n) begin
            @(posedge clk); #1 sample_clk = 1'b1;
            @(posedge clk); #1 sample_clk = 1'b0;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bs_data  = 8'h00;
        bus.bs_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bs_ready",   {31'd0, bus.bs_ready}, 32'd0);
        chk("rst_we",         {31'd0, bus.ram0_we}, 32'd0);
        chk("rst_addr",       {30'd0, bus.ram0_address}, 32'd0);
        chk("rst_datain",     {16'd0, bus.ram0_datain}, 32'd0);
        chk("rst_eth_done",   {31'd0, eth_done}, 32'd1);
        chk("rst_huff_done",  {31'd0, huff_done}, 32'd1);
        chk("rst_dbg_state",  {28'd0, dbg_state}, 32'd0);
        chk("rst_dbg_frames", {16'd0, dbg_frame_count}, 32'd0);

        // stereo frame on the reset credit; mixes wsf=1/0 to check the masked fields
        gcs[0] = {8'h11, 4'h1, 1'b1, 2'd1, 1'b1};
        gcs[1] = {8'h22, 4'h2, 1'b0, 2'd3, 1'b1};
        gcs[2] = {8'h33, 4'h3, 1'b1, 2'd3, 1'b0};
        gcs[3] = {8'h44, 4'h4, 1'b1, 2'd0, 1'b1};
        txq = {8'hFF, 8'hFB, 8'h90, 8'h64};
        add_side_info(1'b0, 1'b1);
        len = txq.size();
        base = acc_cnt; w0 = wr_cnt; f0 = huff_fall;
        @(posedge clk); #1 module_en = 1'b1;
        send_all();
        wait_done("stereo");
        chk("stereo_huff_fall",   huff_fall - f0, 1);
        chk("stereo_writes",      wr_cnt - w0, 4);
        chk("stereo_bytes",       acc_cnt - base, len);
        chk("stereo_eth_done",    {31'd0, eth_done}, 32'd1);
`ifdef DEBUG_HUFF_EN
        chk("stereo_state6_cycles", st6_cnt, 1);
        chk("stereo_frame_count",   {16'd0, dbg_frame_count}, 32'd1);
`endif

        // mono frame must wait for a full 1152 sample-edge credit
        gcs[0] = {8'hA5, 4'h7, 1'b1, 2'd2, 1'b0};
        gcs[2] = {8'h80, 4'h3, 1'b0, 2'd3, 1'b1};
        txq = {8'hFF, 8'hFB, 8'h90, 8'hC4};
        add_side_info(1'b1, 1'b1);
        len = txq.size();
        base = acc_cnt; w0 = wr_cnt; f0 = huff_fall;
        fork
            send_all();
            begin
                repeat (20) @(negedge clk);
                chk("nocredit_bytes", acc_cnt - base, 0);
                pulse_samples(1151);
                repeat (10) @(negedge clk);
                chk("credit1151_bytes", acc_cnt - base, 0);
                chk("credit1151_huff",  {31'd0, huff_done}, 32'd1);
                pulse_samples(1);
            end
        join
        wait_done("mono");
        chk("mono_writes",    wr_cnt - w0, 2);
        chk("mono_bytes",     acc_cnt - base, len);
        chk("mono_huff_fall", huff_fall - f0, 1);

        // rejected headers (bitrate 15, bitrate 0, samplerate 3), repeated FF, then CRC frame
        pulse_samples(1152);
        gcs[0] = {8'h80, 4'h3, 1'b0, 2'd2, 1'b1};
        gcs[2] = {8'h5A, 4'hC, 1'b1, 2'd1, 1'b1};
        txq = {8'h12, 8'hFF, 8'hFB, 8'hF0, 8'hFF, 8'hFB, 8'h00, 8'hFF, 8'hFB, 8'h9C,
               8'hFF, 8'hFF, 8'hFA, 8'h90, 8'hC4, 8'h3C, 8'hA7};
        add_side_info(1'b1, 1'b1);
        len = txq.size();
        base = acc_cnt; w0 = wr_cnt; f0 = huff_fall;
        send_all();
        wait_done("crc");
        chk("crc_writes",    wr_cnt - w0, 2);
        chk("crc_bytes",     acc_cnt - base, len);
        chk("crc_huff_fall", huff_fall - f0, 1);

        // module_en dropped mid side-info
        pulse_samples(1152);
        gcs[0] = {8'hC3, 4'h9, 1'b1, 2'd2, 1'b1};
        gcs[1] = {8'h3C, 4'h6, 1'b0, 2'd1, 1'b0};
        gcs[2] = {8'h01, 4'hF, 1'b1, 2'd3, 1'b1};
        gcs[3] = {8'hFE, 4'h0, 1'b0, 2'd0, 1'b0};
        txq = {8'hFF, 8'hFB, 8'h90, 8'h04};
        add_side_info(1'b0, 1'b1);
        base = acc_cnt; w0 = wr_cnt;
        fork
            send_all();
            begin
                t = 0;
                while (acc_cnt - base < 10 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk); #1 module_en = 1'b0;
                @(negedge clk);
                a1 = acc_cnt;
                en_bad = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    if (bus.bs_ready || bus.ram0_we) en_bad = 1'b1;
                end
                chk("en0_no_ready_or_write", {31'd0, en_bad}, 32'd0);
                chk("en0_bytes_frozen",      acc_cnt, a1);
                chk("en0_writes",            wr_cnt - w0, 0);
                chk("en0_eth_done",          {31'd0, eth_done}, 32'd0);
                chk("en0_huff_done",         {31'd0, huff_done}, 32'd0);
                @(posedge clk); #1 module_en = 1'b1;
            end
        join
        wait_done("en_resume");
        chk("en_resume_writes", wr_cnt - w0, 4);

        // reset in the middle of side info: frame aborted, no writes
        pulse_samples(1152);
        txq = {8'hFF, 8'hFB, 8'h90, 8'h64};
        add_side_info(1'b0, 1'b0);
        base = acc_cnt; w0 = wr_cnt;
        fork
            send_all();
            begin
                t = 0;
                while (acc_cnt - base < 8 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk); #1;
                abort = 1'b1;
                rst = 1'b1;
                module_en = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        txq.delete();
        abort = 1'b0;
        repeat (50) @(negedge clk);
        chk("rstmid_writes",     wr_cnt - w0, 0);
        chk("rstmid_eth_done",   {31'd0, eth_done}, 32'd1);
        chk("rstmid_huff_done",  {31'd0, huff_done}, 32'd1);
        chk("rstmid_datain",     {16'd0, bus.ram0_datain}, 32'd0);
        chk("rstmid_frames",     {16'd0, dbg_frame_count}, 32'd0);

        // the reset credit alone lets the next frame through
        gcs[0] = {8'hA5, 4'h7, 1'b1, 2'd2, 1'b0};
        gcs[2] = {8'h80, 4'h3, 1'b0, 2'd0, 1'b0};
        txq = {8'hFF, 8'hFB, 8'h90, 8'hC4};
        add_side_info(1'b1, 1'b1);
        w0 = wr_cnt;
        @(posedge clk); #1 module_en = 1'b1;
        send_all();
        wait_done("post_reset");
        chk("post_reset_writes", wr_cnt - w0, 2);
`ifdef DEBUG_HUFF_EN
        chk("post_reset_frame_count", {16'd0, dbg_frame_count}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
